inst_loader: RTL and testbench
==============================

# inst_loader

Boot-image loader that drives the write port of the `InstCatch` instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one `wren` pulse per word at consecutive word addresses starting at 0. It holds the core in reset (`cpu_hold`) while an image is being loaded and reports completion or error. It sits between the debug/download byte source and `InstCatch` (`wren`/`wraddr`/`wrdata`).

## Interface
- `DEPTH`, default `` `InstCatchDepth ``: word-address width; capacity is 2^DEPTH words.
- `TIMEOUT`, default 1_000_000: maximum idle cycles between accepted bytes while a frame is in progress.

- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  single-cycle pulse that arms a new load; ignored unless state is IDLE or ERR
- `byte_valid`  in  1  source has a byte
- `byte_data`  in  8  byte value
- `byte_ready`  out  1  loader accepts a byte; a transfer occurs when `byte_valid && byte_ready`
- `wren`  out  1  instruction memory write strobe
- `wraddr`  out  DEPTH  word address
- `wrdata`  out  32  assembled word
- `cpu_hold`  out  1  keeps the core in reset
- `busy`  out  1  high in LEN, DATA and WRITE
- `done`  out  1  one-cycle pulse on successful completion
- `err`  out  1  sticky error flag

## Operation
- Frame format: 4 length bytes N (32-bit little-endian word count), then 4·N payload bytes. Each word is little-endian: byte k of the word goes to `wrdata[8k+7:8k]`.
- States are IDLE, LEN, DATA, WRITE, DONE, ERR.
  - IDLE: `byte_ready`=0. A `start` pulse clears the byte index, word counter, length and `err`, then moves to LEN.
  - LEN: `byte_ready`=1. Shifts 4 bytes into the length register.
    - On the 4th byte with N==0, go to DONE.
    - On the 4th byte with N>2^DEPTH, go to ERR.
    - Otherwise go to DATA.
  - DATA: `byte_ready`=1. Collects bytes into the word register. On the 4th byte, go to WRITE.
  - WRITE: one cycle with `wren`=1, `wraddr`=word counter, `wrdata`=assembled word, and `byte_ready`=0. The word counter (DEPTH+1 bits) then increments. If the new count equals N, go to DONE; otherwise return to DATA.
  - DONE: one cycle with `done`=1 and `cpu_hold`=0, then go to IDLE.
  - ERR: `err`=1 and `cpu_hold`=1 both hold until the next `start` (which re-enters LEN) or reset. `byte_ready`=0.
- `cpu_hold` is 1 in LEN, DATA, WRITE and ERR, and 0 in IDLE and DONE.
- Timeout: in LEN and DATA, an idle counter increments on every cycle without a transfer and clears on each transfer. When it reaches TIMEOUT, the block goes to ERR and no partial word is written. The counter width is clog2(TIMEOUT+1).
- `start` is ignored in LEN, DATA, WRITE and DONE.
- Bytes offered while `byte_ready`=0 are not consumed. The source holds them.

## Timing
- Reset values:
  - State is IDLE.
  - `byte_ready`, `wren`, `cpu_hold`, `busy`, `done`, `err` are all 0.
  - `wraddr`=0 and `wrdata`=0.
- Reset asserted mid-load aborts immediately. The next cycle shows reset values, with no further `wren`. Words already written remain in memory.
- `start` in cycle t puts the block in LEN in cycle t+1, with `byte_ready`=1 and `cpu_hold`=1.
- If the 4th byte of a word is accepted in cycle t, `wren`=1 in cycle t+1 and `byte_ready` returns to 1 in cycle t+2 (when not done). Minimum spacing between writes is 5 cycles.
- After the last `wren` in cycle t, `done` is high in cycle t+1 and the block is in IDLE in cycle t+2.
- `wraddr` and `wrdata` are registered and stable for the whole `wren` cycle. Outside that cycle they hold their last value.
- Only the registered word counter drives `wraddr`. A count of 2^DEPTH is reached only as the terminal value and is never presented as an address.

## Test plan
- Basic load: `start`, then length bytes 02 00 00 00 and payload 13 00 00 00 93 00 10 00, sent back-to-back with `byte_valid`=1.
  - First write: `wren` with `wraddr`=0, `wrdata`=0x00000013.
  - Second write: `wraddr`=1, `wrdata`=0x00100093.
  - `done` pulses once; `cpu_hold` is 1 from the cycle after `start` until DONE.
- Gapped source: same image with `byte_valid` toggling at random, gaps shorter than TIMEOUT. The bench must see the identical writes, `wren` exactly 5+gap cycles apart, and no byte dropped or duplicated.
- Zero length: length bytes 00 00 00 00. Required response: no `wren`, `done` high 1 cycle after the 4th length byte, `err`=0.
- Overflow: N = 2^DEPTH+1. Required response: ERR right after the 4th length byte, `err`=1, `cpu_hold`=1, no `wren`.
  - A subsequent `start` clears `err`.
  - A following valid 1-word image loads to address 0.
- Timeout: run with TIMEOUT=16, send length 1 and then 2 payload bytes, then stall. `err` rises exactly 16 cycles after the last transfer, with no `wren`.
- Reset mid-load: pulse `rst_n`=0 for 1 cycle after word 0 of a 3-word image is written. Next cycle all outputs are at reset values; `start` ignored during reset; no `wren` follows until a new `start`.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-image loader: turns a length-prefixed little-endian byte stream into
// consecutive word writes to the instruction memory while holding the core in reset.
`ifndef InstCatchDepth
`define InstCatchDepth 10
`endif

module inst_loader #(
    parameter int DEPTH   = `InstCatchDepth,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wren,
    output logic [DEPTH-1:0] wraddr,
    output logic [31:0]      wrdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    // The counter reads 0 in the cycle after a transfer, so firing at TIMEOUT-2
    // makes ERR visible exactly TIMEOUT cycles after the last accepted byte.
    localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT - 2);
    localparam logic [32:0]   CAPACITY   = 33'd1 << DEPTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [1:0]       byte_idx_r;
    logic [31:0]      len_r;
    logic [31:0]      word_r;
    logic [DEPTH:0]   word_cnt_r;
    logic [CW-1:0]    idle_cnt_r;

    logic             byte_ready_r, wren_r, cpu_hold_r, busy_r, done_r, err_r;
    logic [DEPTH-1:0] wraddr_r;
    logic [31:0]      wrdata_r;

    logic             byte_ready_nxt_s, wren_nxt_s, cpu_hold_nxt_s;
    logic             busy_nxt_s, done_nxt_s, err_nxt_s;

    logic             xfer_s, last_byte_s, timeout_s;
    logic             len_zero_s, len_over_s, last_word_s;
    logic [31:0]      len_full_s, word_full_s;
    logic [DEPTH:0]   word_cnt_inc_s;

    assign xfer_s         = byte_valid & byte_ready_r;
    assign last_byte_s    = (byte_idx_r == 2'd3);
    assign len_full_s     = {byte_data, len_r[31:8]};
    assign word_full_s    = {byte_data, word_r[31:8]};
    assign len_zero_s     = (len_full_s == 32'd0);
    assign len_over_s     = ({1'b0, len_full_s} > CAPACITY);
    assign word_cnt_inc_s = word_cnt_r + {{DEPTH{1'b0}}, 1'b1};
    assign last_word_s    = ({{(32-DEPTH){1'b0}}, word_cnt_inc_s} == {1'b0, len_r});
    assign timeout_s      = !xfer_s && (idle_cnt_r == IDLE_LIMIT);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_ERR: begin
                if (start) state_nxt_s = S_LEN;
                else       state_nxt_s = state_r;
            end
            S_LEN: begin
                if (xfer_s && last_byte_s) begin
                    if (len_zero_s)      state_nxt_s = S_DONE;
                    else if (len_over_s) state_nxt_s = S_ERR;
                    else                 state_nxt_s = S_DATA;
                end else if (timeout_s) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_LEN;
                end
            end
            S_DATA: begin
                if (xfer_s && last_byte_s) state_nxt_s = S_WRITE;
                else if (timeout_s)        state_nxt_s = S_ERR;
                else                       state_nxt_s = S_DATA;
            end
            S_WRITE: begin
                if (last_word_s) state_nxt_s = S_DONE;
                else             state_nxt_s = S_DATA;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        byte_ready_nxt_s = 1'b0;
        wren_nxt_s       = 1'b0;
        cpu_hold_nxt_s   = 1'b0;
        busy_nxt_s       = 1'b0;
        done_nxt_s       = 1'b0;
        err_nxt_s        = 1'b0;
        case (state_nxt_s)
            S_LEN, S_DATA: begin
                byte_ready_nxt_s = 1'b1;
                cpu_hold_nxt_s   = 1'b1;
                busy_nxt_s       = 1'b1;
            end
            S_WRITE: begin
                wren_nxt_s     = 1'b1;
                cpu_hold_nxt_s = 1'b1;
                busy_nxt_s     = 1'b1;
            end
            S_DONE: done_nxt_s = 1'b1;
            S_ERR: begin
                err_nxt_s      = 1'b1;
                cpu_hold_nxt_s = 1'b1;
            end
            S_IDLE:  byte_ready_nxt_s = 1'b0;
            default: byte_ready_nxt_s = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_ready_r <= 1'b0;
            wren_r       <= 1'b0;
            cpu_hold_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            byte_ready_r <= byte_ready_nxt_s;
            wren_r       <= wren_nxt_s;
            cpu_hold_r   <= cpu_hold_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

    // Datapath: byte assembly, counters, and the write address/data latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx_r <= 2'd0;
            len_r      <= 32'd0;
            word_r     <= 32'd0;
            word_cnt_r <= {(DEPTH+1){1'b0}};
            idle_cnt_r <= {CW{1'b0}};
            wraddr_r   <= {DEPTH{1'b0}};
            wrdata_r   <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        byte_idx_r <= 2'd0;
                        len_r      <= 32'd0;
                        word_r     <= 32'd0;
                        word_cnt_r <= {(DEPTH+1){1'b0}};
                        idle_cnt_r <= {CW{1'b0}};
                    end
                end
                S_LEN, S_DATA: begin
                    if (xfer_s) begin
                        byte_idx_r <= byte_idx_r + 2'd1;
                        idle_cnt_r <= {CW{1'b0}};
                        if (state_r == S_LEN) begin
                            len_r <= len_full_s;
                        end else begin
                            word_r <= word_full_s;
                            // Address is latched only for a complete word, so a
                            // terminal count of 2^DEPTH never reaches wraddr.
                            if (last_byte_s) begin
                                wraddr_r <= word_cnt_r[DEPTH-1:0];
                                wrdata_r <= word_full_s;
                            end
                        end
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CW'(1);
                    end
                end
                S_WRITE: begin
                    word_cnt_r <= word_cnt_inc_s;
                    idle_cnt_r <= {CW{1'b0}};
                end
                default: idle_cnt_r <= {CW{1'b0}};
            endcase
        end
    end

    assign byte_ready = byte_ready_r;
    assign wren       = wren_r;
    assign wraddr     = wraddr_r;
    assign wrdata     = wrdata_r;
    assign cpu_hold   = cpu_hold_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader; expectations come from the
// frame format rules (byte order, write timing relative to accepted bytes).
module tb_inst_loader;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int LOGN    = 16384;

    typedef logic [7:0]  byte_q_t [$];
    typedef logic [31:0] word_q_t [$];

    logic             clk = 1'b0;
    logic             rst_n, start, byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready, wren, cpu_hold, busy, done, err;
    logic [DEPTH-1:0] wraddr;
    logic [31:0]      wrdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic             hold_log [LOGN];
    logic             ready_log[LOGN];
    logic             err_log  [LOGN];
    int               xfer_cyc[$];
    logic [7:0]       xfer_val[$];
    int               wr_cyc[$];
    logic [DEPTH-1:0] wr_addr[$];
    logic [31:0]      wr_data[$];
    int               done_cyc[$];

    inst_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .wren(wren),
        .wraddr(wraddr), .wrdata(wrdata), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled mid-cycle
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            hold_log[cyc]  <= cpu_hold;
            ready_log[cyc] <= byte_ready;
            err_log[cyc]   <= err;
        end
        if (byte_valid && byte_ready) begin
            xfer_cyc.push_back(cyc);
            xfer_val.push_back(byte_data);
        end
        if (wren) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(wraddr);
            wr_data.push_back(wrdata);
        end
        if (done) done_cyc.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        xfer_cyc.delete(); xfer_val.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        done_cyc.delete();
    endtask

    task automatic build_frame(input logic [31:0] n, input word_q_t w, output byte_q_t q);
        q = {};
        for (int k = 0; k < 4; k++) q.push_back(8'((n >> (8 * k)) & 32'hFF));
        foreach (w[i])
            for (int k = 0; k < 4; k++) q.push_back(8'((w[i] >> (8 * k)) & 32'hFF));
    endtask

    task automatic pulse_start(output int sc);
        start = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t q, input int max_gap, output bit ok);
        ok = 1'b1;
        foreach (q[i]) begin
            int  g;
            int  budget;
            bit  taken;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (g > 0) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                repeat (g) begin @(posedge clk); #1; end
            end
            byte_valid = 1'b1;
            byte_data  = q[i];
            taken  = 1'b0;
            budget = 0;
            while (!taken && budget < 64) begin
                @(negedge clk); taken = byte_ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!taken) begin
                ok = 1'b0;
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done || err) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({byte_ready, wren, cpu_hold, busy, done, err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000000", {byte_ready, wren, cpu_hold, busy, done, err});
        end
        vectors++;
        if (wraddr !== {DEPTH{1'b0}}) begin
            miscompares++; $display("FAIL reset_wraddr: got %0h expected 0", wraddr);
        end
        vectors++;
        if (wrdata !== 32'd0) begin
            miscompares++; $display("FAIL reset_wrdata: got %0h expected 0", wrdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_basic();
        word_q_t w;
        byte_q_t q;
        int sc, bad, dc;
        bit ok1, ok2;
        w = '{32'h0000_0013, 32'h0010_0093};
        build_frame(32'd2, w, q);
        clear_logs();
        pulse_start(sc);
        send_bytes(q, 0, ok1);
        wait_end(40, ok2);
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if (!(ok1 && ok2)) begin
            miscompares++; $display("FAIL basic_complete: got send=%0d end=%0d expected 1 1", ok1, ok2);
        end
        vectors++;
        if (ready_log[sc+1] !== 1'b1 || hold_log[sc+1] !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_start_len: got ready=%b hold=%b expected 1 1", ready_log[sc+1], hold_log[sc+1]);
        end
        vectors++;
        if (wr_cyc.size() !== 2) begin
            miscompares++; $display("FAIL basic_wr_count: got %0d expected 2", wr_cyc.size());
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (wr_addr[i] !== DEPTH'(i) || wr_data[i] !== w[i]) begin
                miscompares++;
                $display("FAIL basic_write[%0d]: got %0h/%08h expected %0h/%08h", i, wr_addr[i], wr_data[i], i, w[i]);
            end
            vectors++;
            if (wr_cyc[i] !== xfer_cyc[4*i+7] + 1) begin
                miscompares++;
                $display("FAIL basic_wr_timing[%0d]: got cycle %0d expected %0d", i, wr_cyc[i], xfer_cyc[4*i+7] + 1);
            end
        end
        vectors++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== wr_cyc[1] + 1) begin
            miscompares++;
            $display("FAIL basic_done: got %0d pulses first at %0d expected 1 at %0d", done_cyc.size(), done_cyc[0], wr_cyc[1] + 1);
        end
        dc = done_cyc[0];
        bad = 0;
        for (int c = sc + 1; c < dc; c++) if (hold_log[c] !== 1'b1) bad++;
        vectors++;
        if (bad !== 0 || hold_log[dc] !== 1'b0 || ready_log[dc+1] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_cpu_hold: got %0d low cycles, hold@done=%b ready@idle=%b expected 0 0 0", bad, hold_log[dc], ready_log[dc+1]);
        end
    endtask

    task automatic test_gapped();
        for (int it = 0; it < 4; it++) begin
            word_q_t w;
            byte_q_t q;
            int n, gap, sc, dropped;
            bit ok1, ok2;
            n   = (it == 0) ? (1 << DEPTH) : int'($urandom_range(6, 1));
            gap = (it == 0) ? 0 : int'($urandom_range(6, 1));
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            build_frame(32'(n), w, q);
            clear_logs();
            pulse_start(sc);
            send_bytes(q, gap, ok1);
            wait_end(40, ok2);
            repeat (2) begin @(posedge clk); #1; end
            vectors++;
            if (!(ok1 && ok2) || wr_cyc.size() !== n) begin
                miscompares++;
                $display("FAIL gapped_count it%0d: got %0d writes (send=%0d end=%0d) expected %0d", it, wr_cyc.size(), ok1, ok2, n);
            end
            dropped = 0;
            for (int i = 0; i < q.size(); i++) if (i >= xfer_val.size() || xfer_val[i] !== q[i]) dropped++;
            vectors++;
            if (dropped !== 0 || xfer_val.size() !== q.size()) begin
                miscompares++;
                $display("FAIL gapped_bytes it%0d: got %0d accepted %0d wrong expected %0d exact", it, xfer_val.size(), dropped, q.size());
            end
            for (int i = 0; i < n && i < wr_cyc.size(); i++) begin
                vectors++;
                if (wr_addr[i] !== DEPTH'(i) || wr_data[i] !== w[i] || wr_cyc[i] !== xfer_cyc[4*i+7] + 1) begin
                    miscompares++;
                    $display("FAIL gapped_write it%0d[%0d]: got %0h/%08h@%0d expected %0h/%08h@%0d", it, i,
                             wr_addr[i], wr_data[i], wr_cyc[i], i, w[i], xfer_cyc[4*i+7] + 1);
                end
                if (gap == 0 && i > 0) begin
                    vectors++;
                    if (wr_cyc[i] - wr_cyc[i-1] !== 5) begin
                        miscompares++;
                        $display("FAIL b2b_spacing[%0d]: got %0d expected 5", i, wr_cyc[i] - wr_cyc[i-1]);
                    end
                end
            end
            vectors++;
            if (done_cyc.size() !== 1 || done_cyc[0] !== wr_cyc[n-1] + 1) begin
                miscompares++;
                $display("FAIL gapped_done it%0d: got %0d pulses at %0d expected 1 at %0d", it, done_cyc.size(), done_cyc[0], wr_cyc[n-1] + 1);
            end
        end
    endtask

    task automatic test_zero_len();
        word_q_t w;
        byte_q_t q;
        int sc, dc;
        bit ok1, ok2;
        w = {};
        build_frame(32'd0, w, q);
        clear_logs();
        pulse_start(sc);
        send_bytes(q, 0, ok1);
        wait_end(20, ok2);
        repeat (2) begin @(posedge clk); #1; end
        dc = done_cyc[0];
        vectors++;
        if (done_cyc.size() !== 1 || dc !== xfer_cyc[3] + 1) begin
            miscompares++;
            $display("FAIL zero_done: got %0d pulses at %0d expected 1 at %0d", done_cyc.size(), dc, xfer_cyc[3] + 1);
        end
        vectors++;
        if (wr_cyc.size() !== 0 || err_log[dc] !== 1'b0 || hold_log[dc] !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_side: got %0d writes err=%b hold=%b expected 0 0 0", wr_cyc.size(), err_log[dc], hold_log[dc]);
        end
    endtask

    task automatic test_overflow();
        word_q_t w;
        byte_q_t q;
        int sc, lx;
        bit ok1, ok2;
        logic [31:0] word;
        w = {};
        build_frame(32'((1 << DEPTH) + 1), w, q);
        clear_logs();
        pulse_start(sc);
        send_bytes(q, 0, ok1);
        wait_end(20, ok2);
        repeat (4) begin @(posedge clk); #1; end
        lx = xfer_cyc[3];
        vectors++;
        if (err_log[lx] !== 1'b0 || err_log[lx+1] !== 1'b1 || hold_log[lx+1] !== 1'b1 || err_log[cyc-1] !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_err: got err %b->%b hold=%b later=%b expected 0->1 1 1", err_log[lx], err_log[lx+1], hold_log[lx+1], err_log[cyc-1]);
        end
        vectors++;
        if (wr_cyc.size() !== 0 || done_cyc.size() !== 0) begin
            miscompares++;
            $display("FAIL overflow_quiet: got %0d writes %0d done expected 0 0", wr_cyc.size(), done_cyc.size());
        end
        word = $urandom;
        w = '{word};
        build_frame(32'd1, w, q);
        clear_logs();
        pulse_start(sc);
        send_bytes(q, 2, ok1);
        wait_end(40, ok2);
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if (err_log[sc+1] !== 1'b0) begin
            miscompares++; $display("FAIL overflow_clear: got err=%b expected 0", err_log[sc+1]);
        end
        vectors++;
        if (wr_cyc.size() !== 1 || wr_addr[0] !== {DEPTH{1'b0}} || wr_data[0] !== word || done_cyc.size() !== 1) begin
            miscompares++;
            $display("FAIL overflow_reload: got %0d writes %0h/%08h done=%0d expected 1 0/%08h 1", wr_cyc.size(), wr_addr[0], wr_data[0], done_cyc.size(), word);
        end
    endtask

    task automatic test_timeout();
        word_q_t w;
        byte_q_t q;
        int sc, lx, first;
        bit ok1;
        w = {};
        build_frame(32'd1, w, q);
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        clear_logs();
        pulse_start(sc);
        send_bytes(q, 0, ok1);
        repeat (40) begin @(posedge clk); #1; end
        lx = xfer_cyc[5];
        first = -1;
        for (int c = lx + 1; c < lx + 40; c++) if (err_log[c] === 1'b1 && first < 0) first = c;
        vectors++;
        if (!ok1 || xfer_cyc.size() !== 6 || first !== lx + TIMEOUT) begin
            miscompares++;
            $display("FAIL timeout_err: got err at +%0d (%0d bytes) expected +%0d", first - lx, xfer_cyc.size(), TIMEOUT);
        end
        vectors++;
        if (wr_cyc.size() !== 0) begin
            miscompares++; $display("FAIL timeout_nowrite: got %0d writes expected 0", wr_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        word_q_t w;
        byte_q_t q;
        int sc, idx, nx, busy_rdy;
        bit seen, taken;
        w = '{$urandom, $urandom, $urandom};
        build_frame(32'd3, w, q);
        clear_logs();
        pulse_start(sc);
        idx = 0; seen = 1'b0;
        byte_valid = 1'b1; byte_data = q[0];
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk); taken = byte_ready; seen = wren;
            @(posedge clk); #1;
            if (taken) begin
                idx++;
                if (idx < q.size()) byte_data = q[idx];
            end
        end
        vectors++;
        if (!seen || wr_data[0] !== w[0]) begin
            miscompares++; $display("FAIL rstmid_first: got seen=%0d data=%08h expected 1 %08h", seen, wr_data[0], w[0]);
        end
        byte_valid = 1'b0;
        rst_n = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({byte_ready, wren, cpu_hold, busy, done, err, wraddr, wrdata} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_values: got rdy=%b wren=%b hold=%b busy=%b done=%b err=%b addr=%0h data=%08h expected all 0",
                     byte_ready, wren, cpu_hold, busy, done, err, wraddr, wrdata);
        end
        @(posedge clk); #1;
        nx = xfer_cyc.size();
        byte_valid = 1'b1; byte_data = 8'($urandom);
        busy_rdy = 0;
        repeat (20) begin
            @(negedge clk); if (byte_ready !== 1'b0 || cpu_hold !== 1'b0) busy_rdy++;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        vectors++;
        if (wr_cyc.size() !== 1 || xfer_cyc.size() !== nx || done_cyc.size() !== 0 || busy_rdy !== 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet: got %0d writes %0d new bytes %0d done %0d active expected 1 0 0 0",
                     wr_cyc.size(), xfer_cyc.size() - nx, done_cyc.size(), busy_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_zero_len();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
